// File: rtl/parking_gate_controller.sv
// -----------------------------------------------------------------------------
// parking_gate_controller
// Lane controller in front of the parking occupancy counter. Two independent
// FSMs drive the entry and exit barriers from synchronised loop/beam/tag
// sensors and emit one clean car_entered / car_exited strobe per passage,
// with the car class held stable across the strobe's falling edge.
//
// Optional feature macro: GATE_TIMEOUT_EN
//   When defined, an open gate that sees no passage within TIMEOUT_CYCLES
//   closes, pulses gate_timeout and reports nothing. When undefined, an open
//   gate waits indefinitely and gate_timeout is tied low.
// -----------------------------------------------------------------------------
module parking_gate_controller #(
    parameter int PULSE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_arrive,
    input  logic in_is_uni,
    input  logic in_passed,
    input  logic out_arrive,
    input  logic out_is_uni,
    input  logic out_passed,
    input  logic uni_is_vacated_space,
    input  logic is_vacated_space,
    output logic gate_in_open,
    output logic gate_out_open,
    output logic car_entered,
    output logic is_uni_car_entered,
    output logic car_exited,
    output logic is_uni_car_exited,
    output logic entry_denied,
    output logic gate_timeout
);

    // Reject parameter values the 4-bit strobe counter or the lane logic
    // cannot honour.
    generate
        if (PULSE_CYCLES < 1 || PULSE_CYCLES > 15 || SYNC_STAGES < 1 || TIMEOUT_CYCLES < 1) begin : g_badParams
            $error("parking_gate_controller: illegal parameter value");
        end
    endgenerate

    localparam int NUM_SYNC = 6;
    localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);

    typedef enum logic [2:0] {
        IN_IDLE,
        IN_CHECK,
        IN_OPEN,
        IN_PASS,
        IN_REPORT,
        IN_HOLD,
        IN_WAIT_LEAVE
    } entryState_t;

    typedef enum logic [2:0] {
        OUT_IDLE,
        OUT_OPEN,
        OUT_PASS,
        OUT_REPORT,
        OUT_HOLD,
        OUT_WAIT_LEAVE
    } exitState_t;

    // Synchroniser chain, bit order matches w_rawSensors below.
    logic [SYNC_STAGES-1:0][NUM_SYNC-1:0] r_syncChain;
    logic [NUM_SYNC-1:0] w_rawSensors;

    logic w_inArriveS;
    logic w_inIsUniS;
    logic w_inPassedS;
    logic w_outArriveS;
    logic w_outIsUniS;
    logic w_outPassedS;

    // Entry lane state
    entryState_t r_inState;
    entryState_t w_inNext;
    logic        r_inCls;
    logic [3:0]  r_inPulseCnt;
    logic        r_inPassedQ;
    logic        w_inPassedRise;
    logic        w_inVacancy;
    logic        w_entryDenied;

    // Exit lane state
    exitState_t  r_outState;
    exitState_t  w_outNext;
    logic        r_outCls;
    logic [3:0]  r_outPulseCnt;
    logic        r_outPassedQ;
    logic        w_outPassedRise;

`ifdef GATE_TIMEOUT_EN
    localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] r_inWaitCnt;
    logic [TIMEOUT_W-1:0] r_outWaitCnt;
    logic                 r_inTimeout;
    logic                 r_outTimeout;
`endif

    assign w_rawSensors = {out_passed, out_is_uni, out_arrive, in_passed, in_is_uni, in_arrive};

    // Bring every lane sensor and tag into the clock domain before any FSM looks at it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_syncChain <= '0;
        end else begin
            r_syncChain[0] <= w_rawSensors;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_syncChain[i] <= r_syncChain[i-1];
            end
        end
    end

    assign w_inArriveS  = r_syncChain[SYNC_STAGES-1][0];
    assign w_inIsUniS   = r_syncChain[SYNC_STAGES-1][1];
    assign w_inPassedS  = r_syncChain[SYNC_STAGES-1][2];
    assign w_outArriveS = r_syncChain[SYNC_STAGES-1][3];
    assign w_outIsUniS  = r_syncChain[SYNC_STAGES-1][4];
    assign w_outPassedS = r_syncChain[SYNC_STAGES-1][5];

    // Delayed beam copies so OPEN reacts to a fresh beam break, not a stale level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inPassedQ  <= 1'b0;
            r_outPassedQ <= 1'b0;
        end else begin
            r_inPassedQ  <= w_inPassedS;
            r_outPassedQ <= w_outPassedS;
        end
    end

    assign w_inPassedRise  = w_inPassedS  & ~r_inPassedQ;
    assign w_outPassedRise = w_outPassedS & ~r_outPassedQ;

    // The vacancy flag that matters is picked by the class latched at arrival.
    assign w_inVacancy = r_inCls ? uni_is_vacated_space : is_vacated_space;

    // ------------------------------------------------------------------ entry

    // Entry lane state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inState <= IN_IDLE;
        end else begin
            r_inState <= w_inNext;
        end
    end

    // Entry lane next-state: vacancy check, passage tracking and strobe sequencing.
    always_comb begin
        w_inNext      = r_inState;
        w_entryDenied = 1'b0;
        case (r_inState)
            IN_IDLE: begin
                if (w_inArriveS) begin
                    w_inNext = IN_CHECK;
                end
            end
            IN_CHECK: begin
                if (w_inVacancy) begin
                    w_inNext = IN_OPEN;
                end else begin
                    w_entryDenied = 1'b1;
                    w_inNext      = IN_WAIT_LEAVE;
                end
            end
            IN_OPEN: begin
                if (w_inPassedRise) begin
                    w_inNext = IN_PASS;
                end
`ifdef GATE_TIMEOUT_EN
                else if (r_inWaitCnt == TIMEOUT_LAST) begin
                    w_inNext = IN_WAIT_LEAVE;
                end
`endif
            end
            IN_PASS: begin
                if (!w_inPassedS) begin
                    w_inNext = IN_REPORT;
                end
            end
            IN_REPORT: begin
                if (r_inPulseCnt == PULSE_LAST) begin
                    w_inNext = IN_HOLD;
                end
            end
            IN_HOLD: begin
                w_inNext = IN_WAIT_LEAVE;
            end
            IN_WAIT_LEAVE: begin
                if (!w_inArriveS) begin
                    w_inNext = IN_IDLE;
                end
            end
            default: begin
                w_inNext = IN_IDLE;
            end
        endcase
    end

    // Capture the entering car's class at arrival and time the entry strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inCls      <= 1'b0;
            r_inPulseCnt <= 4'd0;
        end else begin
            if (r_inState == IN_IDLE && w_inArriveS) begin
                r_inCls <= w_inIsUniS;
            end
            r_inPulseCnt <= (r_inState == IN_REPORT) ? r_inPulseCnt + 4'd1 : 4'd0;
        end
    end

    assign gate_in_open       = (r_inState == IN_OPEN) || (r_inState == IN_PASS);
    assign car_entered        = (r_inState == IN_REPORT);
    assign is_uni_car_entered = r_inCls && ((r_inState == IN_REPORT) || (r_inState == IN_HOLD));
    assign entry_denied       = w_entryDenied;

    // ------------------------------------------------------------------- exit

    // Exit lane state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outState <= OUT_IDLE;
        end else begin
            r_outState <= w_outNext;
        end
    end

    // Exit lane next-state: every exit is admitted and reported.
    always_comb begin
        w_outNext = r_outState;
        case (r_outState)
            OUT_IDLE: begin
                if (w_outArriveS) begin
                    w_outNext = OUT_OPEN;
                end
            end
            OUT_OPEN: begin
                if (w_outPassedRise) begin
                    w_outNext = OUT_PASS;
                end
`ifdef GATE_TIMEOUT_EN
                else if (r_outWaitCnt == TIMEOUT_LAST) begin
                    w_outNext = OUT_WAIT_LEAVE;
                end
`endif
            end
            OUT_PASS: begin
                if (!w_outPassedS) begin
                    w_outNext = OUT_REPORT;
                end
            end
            OUT_REPORT: begin
                if (r_outPulseCnt == PULSE_LAST) begin
                    w_outNext = OUT_HOLD;
                end
            end
            OUT_HOLD: begin
                w_outNext = OUT_WAIT_LEAVE;
            end
            OUT_WAIT_LEAVE: begin
                if (!w_outArriveS) begin
                    w_outNext = OUT_IDLE;
                end
            end
            default: begin
                w_outNext = OUT_IDLE;
            end
        endcase
    end

    // Capture the leaving car's class at arrival and time the exit strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outCls      <= 1'b0;
            r_outPulseCnt <= 4'd0;
        end else begin
            if (r_outState == OUT_IDLE && w_outArriveS) begin
                r_outCls <= w_outIsUniS;
            end
            r_outPulseCnt <= (r_outState == OUT_REPORT) ? r_outPulseCnt + 4'd1 : 4'd0;
        end
    end

    assign gate_out_open     = (r_outState == OUT_OPEN) || (r_outState == OUT_PASS);
    assign car_exited        = (r_outState == OUT_REPORT);
    assign is_uni_car_exited = r_outCls && ((r_outState == OUT_REPORT) || (r_outState == OUT_HOLD));

    // ---------------------------------------------------------------- timeout

`ifdef GATE_TIMEOUT_EN
    // Count cycles spent waiting in OPEN on each lane; any other state clears the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inWaitCnt  <= '0;
            r_outWaitCnt <= '0;
        end else begin
            r_inWaitCnt  <= (r_inState  == IN_OPEN)  ? r_inWaitCnt  + TIMEOUT_W'(1) : '0;
            r_outWaitCnt <= (r_outState == OUT_OPEN) ? r_outWaitCnt + TIMEOUT_W'(1) : '0;
        end
    end

    // Flag an abort in the first cycle after the gate has closed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inTimeout  <= 1'b0;
            r_outTimeout <= 1'b0;
        end else begin
            r_inTimeout  <= (r_inState  == IN_OPEN)  && (w_inNext  == IN_WAIT_LEAVE);
            r_outTimeout <= (r_outState == OUT_OPEN) && (w_outNext == OUT_WAIT_LEAVE);
        end
    end

    assign gate_timeout = r_inTimeout | r_outTimeout;
`else
    assign gate_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_parking_gate_controller.sv
// -----------------------------------------------------------------------------
// tb_parking_gate_controller
// Directed bench for parking_gate_controller (PULSE_CYCLES=4, SYNC_STAGES=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Builds with or without GATE_TIMEOUT_EN; the timeout scenario adapts.
// -----------------------------------------------------------------------------
module tb_parking_gate_controller;

`ifdef GATE_TIMEOUT_EN
    localparam int TB_TIMEOUT = 10;
`else
    localparam int TB_TIMEOUT = 1000;
`endif

    logic clk;
    logic rst_n;
    logic in_arrive, in_is_uni, in_passed;
    logic out_arrive, out_is_uni, out_passed;
    logic uni_is_vacated_space, is_vacated_space;
    logic gate_in_open, gate_out_open;
    logic car_entered, is_uni_car_entered;
    logic car_exited, is_uni_car_exited;
    logic entry_denied, gate_timeout;
    logic [7:0] allOutputs;

    int vectors = 0;
    int miscompares = 0;

    parking_gate_controller #(
        .PULSE_CYCLES  (4),
        .TIMEOUT_CYCLES(TB_TIMEOUT),
        .SYNC_STAGES   (2)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_arrive           (in_arrive),
        .in_is_uni           (in_is_uni),
        .in_passed           (in_passed),
        .out_arrive          (out_arrive),
        .out_is_uni          (out_is_uni),
        .out_passed          (out_passed),
        .uni_is_vacated_space(uni_is_vacated_space),
        .is_vacated_space    (is_vacated_space),
        .gate_in_open        (gate_in_open),
        .gate_out_open       (gate_out_open),
        .car_entered         (car_entered),
        .is_uni_car_entered  (is_uni_car_entered),
        .car_exited          (car_exited),
        .is_uni_car_exited   (is_uni_car_exited),
        .entry_denied        (entry_denied),
        .gate_timeout        (gate_timeout)
    );

    assign allOutputs = {gate_in_open, gate_out_open, car_entered, is_uni_car_entered,
                         car_exited, is_uni_car_exited, entry_denied, gate_timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        in_arrive = 0; in_is_uni = 0; in_passed = 0;
        out_arrive = 0; out_is_uni = 0; out_passed = 0;
    endtask

    task automatic test_reset();
        int nonZero;
        clearInputs();
        uni_is_vacated_space = 1; is_vacated_space = 1;
        rst_n = 1;
        #2 rst_n = 0;
        #1;
        vectors++;
        if (allOutputs !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %b, expected %b", allOutputs, 8'h00);
        end
        step(); step();
        rst_n = 1;
        nonZero = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (allOutputs !== 8'h00) nonZero++;
        end
        vectors++;
        if (nonZero != 0) begin
            miscompares++;
            $display("[TB] FAIL idle_after_reset: nonzero cycles %0d, expected 0", nonZero);
        end
    endtask

    task automatic test_public_entry();
        int firstHigh, highCount, uniSeen;
        is_vacated_space = 1; uni_is_vacated_space = 0;
        in_is_uni = 0; in_arrive = 1;
        repeat (3) step();
        vectors++;
        if (gate_in_open !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL pub_gate_early: got %b, expected 0", gate_in_open);
        end
        step();
        vectors++;
        if (gate_in_open !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pub_gate_latency: got %b, expected 1", gate_in_open);
        end
        step(); step();
        in_passed = 1;
        repeat (3) step();
        in_passed = 0;
        firstHigh = -1; highCount = 0; uniSeen = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (car_entered === 1'b1) begin
                if (firstHigh < 0) firstHigh = k;
                highCount++;
            end
            if (is_uni_car_entered !== 1'b0) uniSeen++;
            if (k == 2) begin
                vectors++;
                if (gate_in_open !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL pub_gate_in_pass: got %b, expected 1", gate_in_open);
                end
            end
            if (k == 3) begin
                vectors++;
                if (gate_in_open !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL pub_gate_close: got %b, expected 0", gate_in_open);
                end
            end
        end
        vectors++;
        if (firstHigh != 3) begin
            miscompares++;
            $display("[TB] FAIL pub_strobe_start: got %0d, expected 3", firstHigh);
        end
        vectors++;
        if (highCount != 4) begin
            miscompares++;
            $display("[TB] FAIL pub_strobe_len: got %0d, expected 4", highCount);
        end
        vectors++;
        if (uniSeen != 0) begin
            miscompares++;
            $display("[TB] FAIL pub_class: uni cycles %0d, expected 0", uniSeen);
        end
        in_arrive = 0;
        repeat (4) step();
    endtask

    task automatic test_uni_denied();
        int firstDenied, deniedCount, gateSeen, strobeSeen, firstUni, uniCount;
        is_vacated_space = 1; uni_is_vacated_space = 0;
        in_is_uni = 1; in_arrive = 1;
        firstDenied = -1; deniedCount = 0; gateSeen = 0; strobeSeen = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (entry_denied === 1'b1) begin
                if (firstDenied < 0) firstDenied = k;
                deniedCount++;
            end
            if (gate_in_open !== 1'b0) gateSeen++;
            if (car_entered !== 1'b0) strobeSeen++;
        end
        vectors++;
        if (firstDenied != 3 || deniedCount != 1) begin
            miscompares++;
            $display("[TB] FAIL deny_pulse: first %0d count %0d, expected first 3 count 1", firstDenied, deniedCount);
        end
        vectors++;
        if (gateSeen != 0 || strobeSeen != 0) begin
            miscompares++;
            $display("[TB] FAIL deny_no_gate: gate %0d strobe %0d, expected 0 0", gateSeen, strobeSeen);
        end
        // Vacancy appearing while the refused car still sits on the loop must not reopen.
        uni_is_vacated_space = 1;
        gateSeen = 0; deniedCount = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (gate_in_open !== 1'b0) gateSeen++;
            if (entry_denied !== 1'b0) deniedCount++;
        end
        vectors++;
        if (gateSeen != 0 || deniedCount != 0) begin
            miscompares++;
            $display("[TB] FAIL deny_wait_leave: gate %0d denied %0d, expected 0 0", gateSeen, deniedCount);
        end
        in_arrive = 0;
        repeat (4) step();
        in_arrive = 1;
        repeat (3) step();
        vectors++;
        if (gate_in_open !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL uni_gate_early: got %b, expected 0", gate_in_open);
        end
        step();
        vectors++;
        if (gate_in_open !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL uni_gate_latency: got %b, expected 1", gate_in_open);
        end
        step(); step();
        in_passed = 1;
        repeat (3) step();
        in_passed = 0;
        firstUni = -1; uniCount = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (is_uni_car_entered === 1'b1) begin
                if (firstUni < 0) firstUni = k;
                uniCount++;
            end
        end
        vectors++;
        if (firstUni != 3 || uniCount != 5) begin
            miscompares++;
            $display("[TB] FAIL uni_class_hold: first %0d count %0d, expected first 3 count 5", firstUni, uniCount);
        end
        in_arrive = 0; in_is_uni = 0;
        repeat (4) step();
    endtask

    task automatic test_simultaneous();
        logic [3:0] expected;
        logic [3:0] observed;
        is_vacated_space = 1; uni_is_vacated_space = 1;
        in_is_uni = 0; in_arrive = 1;
        step();
        out_is_uni = 1; out_arrive = 1;
        repeat (2) step();
        vectors++;
        if ({gate_in_open, gate_out_open} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL sim_gates_early: got %b, expected 00", {gate_in_open, gate_out_open});
        end
        step();
        vectors++;
        if ({gate_in_open, gate_out_open} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL sim_gates_open: got %b, expected 11", {gate_in_open, gate_out_open});
        end
        step(); step();
        in_passed = 1; out_passed = 1;
        repeat (3) step();
        in_passed = 0; out_passed = 0;
        for (int k = 1; k <= 9; k++) begin
            step();
            expected = {(k >= 3 && k <= 6), 1'b0, (k >= 3 && k <= 6), (k >= 3 && k <= 7)};
            observed = {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited};
            vectors++;
            if (observed !== expected) begin
                miscompares++;
                $display("[TB] FAIL sim_strobes step %0d: got %b, expected %b", k, observed, expected);
            end
        end
        in_arrive = 0; out_arrive = 0; out_is_uni = 0;
        repeat (4) step();
    endtask

    task automatic test_stay_on_loop();
        int strobeRises, gateRises;
        logic prevStrobe, prevGate;
        is_vacated_space = 1;
        in_is_uni = 0; in_arrive = 1;
        strobeRises = 0; gateRises = 0; prevStrobe = 0; prevGate = 0;
        for (int k = 1; k <= 60; k++) begin
            if (k == 7)  in_passed = 1;
            if (k == 10) in_passed = 0;
            step();
            if (car_entered === 1'b1 && prevStrobe === 1'b0) strobeRises++;
            if (gate_in_open === 1'b1 && prevGate === 1'b0) gateRises++;
            prevStrobe = car_entered;
            prevGate = gate_in_open;
        end
        vectors++;
        if (strobeRises != 1) begin
            miscompares++;
            $display("[TB] FAIL loop_one_strobe: got %0d, expected 1", strobeRises);
        end
        vectors++;
        if (gateRises != 1) begin
            miscompares++;
            $display("[TB] FAIL loop_one_gate: got %0d, expected 1", gateRises);
        end
        in_arrive = 0;
        repeat (4) step();
    endtask

    task automatic test_reset_mid_report();
        int nonZero;
        is_vacated_space = 1;
        in_is_uni = 0; in_arrive = 1;
        step();
        out_is_uni = 1; out_arrive = 1;
        repeat (5) step();
        in_passed = 1; out_passed = 1;
        repeat (3) step();
        in_passed = 0; out_passed = 0;
        repeat (4) step();
        vectors++;
        if ({car_entered, car_exited, is_uni_car_exited} !== 3'b111) begin
            miscompares++;
            $display("[TB] FAIL rst_precondition: got %b, expected 111", {car_entered, car_exited, is_uni_car_exited});
        end
        #2 rst_n = 0;
        #1;
        vectors++;
        if (allOutputs !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL rst_async_clear: got %b, expected %b", allOutputs, 8'h00);
        end
        clearInputs();
        step(); step();
        rst_n = 1;
        nonZero = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (allOutputs !== 8'h00) nonZero++;
        end
        vectors++;
        if (nonZero != 0) begin
            miscompares++;
            $display("[TB] FAIL rst_no_leftover: nonzero cycles %0d, expected 0", nonZero);
        end
        in_arrive = 1; out_arrive = 1;
        repeat (2) step();
        vectors++;
        if ({gate_in_open, gate_out_open} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL rst_idle_early: got %b, expected 00", {gate_in_open, gate_out_open});
        end
        step();
        vectors++;
        if ({gate_in_open, gate_out_open} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL rst_idle_exit: got %b, expected 01", {gate_in_open, gate_out_open});
        end
        step();
        vectors++;
        if ({gate_in_open, gate_out_open} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL rst_idle_entry: got %b, expected 11", {gate_in_open, gate_out_open});
        end
        clearInputs();
        #2 rst_n = 0;
        step();
        rst_n = 1;
        step();
    endtask

    task automatic test_timeout();
`ifdef GATE_TIMEOUT_EN
        int firstGate, gateCount, firstTo, toCount, strobes;
        is_vacated_space = 1;
        in_arrive = 1;
        firstGate = -1; gateCount = 0; firstTo = -1; toCount = 0; strobes = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (gate_in_open === 1'b1) begin
                if (firstGate < 0) firstGate = k;
                gateCount++;
            end
            if (gate_timeout === 1'b1) begin
                if (firstTo < 0) firstTo = k;
                toCount++;
            end
            if (car_entered !== 1'b0) strobes++;
        end
        vectors++;
        if (firstGate != 4 || gateCount != 10) begin
            miscompares++;
            $display("[TB] FAIL to_in_gate: first %0d count %0d, expected first 4 count 10", firstGate, gateCount);
        end
        vectors++;
        if (firstTo != 14 || toCount != 1 || strobes != 0) begin
            miscompares++;
            $display("[TB] FAIL to_in_pulse: first %0d count %0d strobes %0d, expected 14 1 0", firstTo, toCount, strobes);
        end
        in_arrive = 0;
        repeat (4) step();
        out_arrive = 1;
        firstGate = -1; gateCount = 0; firstTo = -1; toCount = 0; strobes = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (gate_out_open === 1'b1) begin
                if (firstGate < 0) firstGate = k;
                gateCount++;
            end
            if (gate_timeout === 1'b1) begin
                if (firstTo < 0) firstTo = k;
                toCount++;
            end
            if (car_exited !== 1'b0) strobes++;
        end
        vectors++;
        if (firstGate != 3 || gateCount != 10) begin
            miscompares++;
            $display("[TB] FAIL to_out_gate: first %0d count %0d, expected first 3 count 10", firstGate, gateCount);
        end
        vectors++;
        if (firstTo != 13 || toCount != 1 || strobes != 0) begin
            miscompares++;
            $display("[TB] FAIL to_out_pulse: first %0d count %0d strobes %0d, expected 13 1 0", firstTo, toCount, strobes);
        end
        out_arrive = 0;
        repeat (4) step();
`else
        int gateCount, toCount, strobes;
        is_vacated_space = 1;
        in_arrive = 1;
        gateCount = 0; toCount = 0;
        for (int k = 1; k <= 1004; k++) begin
            step();
            if (gate_in_open === 1'b1) gateCount++;
            if (gate_timeout !== 1'b0) toCount++;
        end
        vectors++;
        if (gateCount != 1001 || gate_in_open !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL no_to_gate: open cycles %0d now %b, expected 1001 1", gateCount, gate_in_open);
        end
        vectors++;
        if (toCount != 0) begin
            miscompares++;
            $display("[TB] FAIL no_to_pulse: got %0d, expected 0", toCount);
        end
        in_passed = 1;
        repeat (3) step();
        in_passed = 0;
        strobes = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (car_entered === 1'b1) strobes++;
        end
        vectors++;
        if (strobes != 4) begin
            miscompares++;
            $display("[TB] FAIL no_to_late_pass: strobe cycles %0d, expected 4", strobes);
        end
        in_arrive = 0;
        repeat (4) step();
`endif
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_public_entry();
        test_uni_denied();
        test_simultaneous();
        test_stay_on_loop();
        test_reset_mid_report();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
